mem_port_arbiter: RTL

Shares the single data-memory port between the load requester and the store requester in the memory stage. Store requests carry the effective address `rs1 + imm` and the store data from the combinational address/data unit. The block grants one requester at a time and drives a registered one-cycle memory command. It then waits for the memory response and returns the response to the granted requester. Only one memory transaction is outstanding at any time.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Load/store arbiter for the single data-memory port, one transaction outstanding.
// Optional load-starvation guard compiled in with MEM_ARB_FAIR_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ld_req_valid,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    output logic        ld_req_ready,
    output logic        ld_resp_valid,
    output logic [31:0] ld_resp_data,
    input  logic        st_req_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_req_ready,
    output logic        st_done,
    output logic [1:0]  mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
    end

    state_t state, state_nxt;
    logic   owner_st;
    logic   ld_due;
    logic   hs_ld, hs_st;

    assign hs_ld = ld_req_valid && ld_req_ready;
    assign hs_st = st_req_valid && st_req_ready;

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] starve_cnt;

    assign ld_due = (starve_cnt == 4'(STARVE_LIMIT));

    // Counts store wins over a waiting load; never exceeds the limit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (hs_ld || !ld_req_valid) starve_cnt <= 4'd0;
            else if (hs_st)             starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign ld_due = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs_ld || hs_st) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mem_resp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Readies are gated by reset so they read 0 while reset is held.
    always_comb begin
        st_req_ready = 1'b0;
        ld_req_ready = 1'b0;
        if (reset_n && state == IDLE) begin
            st_req_ready = st_req_valid && !(ld_req_valid && ld_due);
            ld_req_ready = ld_req_valid && !st_req_ready;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_cmd       <= CMD_NONE;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            mem_size      <= 2'd0;
            owner_st      <= 1'b0;
            ld_resp_valid <= 1'b0;
            ld_resp_data  <= 32'd0;
            st_done       <= 1'b0;
        end else begin
            mem_cmd       <= CMD_NONE;
            ld_resp_valid <= 1'b0;
            st_done       <= 1'b0;
            if (hs_st) begin
                mem_cmd   <= CMD_STORE;
                mem_addr  <= st_addr;
                mem_wdata <= st_data;
                mem_size  <= st_size;
                owner_st  <= 1'b1;
            end else if (hs_ld) begin
                mem_cmd  <= CMD_LOAD;
                mem_addr <= ld_addr;
                mem_size <= ld_size;
                owner_st <= 1'b0;
            end
            if (state == WAIT && mem_resp_valid) begin
                if (owner_st) begin
                    st_done <= 1'b1;
                end else begin
                    ld_resp_valid <= 1'b1;
                    ld_resp_data  <= mem_resp_data;
                end
            end
        end
    end

endmodule
